// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter sharing one UART TX core among NUM_REQ byte-stream requesters.
// Build option: define ARB_TAG_EN to prefix every packet with a source tag byte (8'hA0 | grant_id).
module uart_tx_arbiter #(
    parameter int          NUM_REQ       = 3,
    parameter logic [15:0] STALL_TIMEOUT = 16'd1000,
    parameter int          CNT_W         = 16
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*8-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           uart_tx_data,
    output logic                 uart_tx_start,
    input  logic                 uart_tx_done,
    output logic                 grant_valid,
    output logic [2:0]           grant_id,
    output logic [CNT_W-1:0]     pkt_bytes,
    output logic                 stall_abort
);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_SEND      = 2'd1;
    localparam logic [1:0] ST_WAIT_DONE = 2'd2;
`ifdef ARB_TAG_EN
    localparam logic [1:0] ST_TAG       = 2'd3;
`endif

    logic [1:0]         state;
    logic [2:0]         last_grant;
    logic [15:0]        stall_cnt;
    logic [15:0]        stall_next;
    logic               last_latched;
    logic [CNT_W-1:0]   pkt_next;

    logic               sel_valid;
    logic               sel_last;
    logic [7:0]         sel_data;
    logic [NUM_REQ-1:0] grant_onehot;

    logic               lo_found;
    logic               hi_found;
    logic [2:0]         lo_pick;
    logic [2:0]         hi_pick;
    logic               arb_found;
    logic [2:0]         arb_pick;

    // Route the granted requester's valid/data/last and build its one-hot ready mask.
    always_comb begin
        sel_valid    = 1'b0;
        sel_last     = 1'b0;
        sel_data     = 8'd0;
        grant_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == 3'(i)) begin
                sel_valid       = req_valid[i];
                sel_last        = req_last[i];
                sel_data        = req_data[8*i +: 8];
                grant_onehot[i] = 1'b1;
            end
        end
    end

    // Round-robin: lowest requester above last_grant wins, otherwise wrap to the lowest one.
    always_comb begin
        lo_found = 1'b0;
        hi_found = 1'b0;
        lo_pick  = 3'd0;
        hi_pick  = 3'd0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                lo_found = 1'b1;
                lo_pick  = 3'(i);
                if (3'(i) > last_grant) begin
                    hi_found = 1'b1;
                    hi_pick  = 3'(i);
                end
            end
        end
        arb_found = lo_found;
        arb_pick  = hi_found ? hi_pick : lo_pick;
    end

    assign stall_next = stall_cnt + 16'd1;
    assign pkt_next   = (&pkt_bytes) ? pkt_bytes : pkt_bytes + CNT_W'(1);

    // Start, ready and abort are registered single-cycle pulses; data and counters hold.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= ST_IDLE;
            last_grant    <= 3'(NUM_REQ - 1);
            stall_cnt     <= 16'd0;
            last_latched  <= 1'b0;
            req_ready     <= '0;
            uart_tx_data  <= 8'd0;
            uart_tx_start <= 1'b0;
            grant_valid   <= 1'b0;
            grant_id      <= 3'd0;
            pkt_bytes     <= '0;
            stall_abort   <= 1'b0;
        end else begin
            uart_tx_start <= 1'b0;
            req_ready     <= '0;
            stall_abort   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (arb_found) begin
                        grant_id    <= arb_pick;
                        grant_valid <= 1'b1;
                        pkt_bytes   <= '0;
                        stall_cnt   <= 16'd0;
`ifdef ARB_TAG_EN
                        state       <= ST_TAG;
`else
                        state       <= ST_SEND;
`endif
                    end
                end
                ST_SEND: begin
                    if (sel_valid) begin
                        uart_tx_data  <= sel_data;
                        uart_tx_start <= 1'b1;
                        req_ready     <= grant_onehot;
                        last_latched  <= sel_last;
                        pkt_bytes     <= pkt_next;
                        stall_cnt     <= 16'd0;
                        state         <= ST_WAIT_DONE;
                    end else if (stall_next >= STALL_TIMEOUT) begin
                        stall_abort <= 1'b1;
                        last_grant  <= grant_id;
                        grant_valid <= 1'b0;
                        stall_cnt   <= 16'd0;
                        state       <= ST_IDLE;
                    end else begin
                        stall_cnt <= stall_next;
                    end
                end
                ST_WAIT_DONE: begin
                    if (uart_tx_done) begin
                        if (last_latched) begin
                            last_grant  <= grant_id;
                            grant_valid <= 1'b0;
                            state       <= ST_IDLE;
                        end else begin
                            state <= ST_SEND;
                        end
                    end
                end
`ifdef ARB_TAG_EN
                // The tag byte is never the end of a packet, so its done always leads to SEND.
                ST_TAG: begin
                    uart_tx_data  <= 8'hA0 | {5'd0, grant_id};
                    uart_tx_start <= 1'b1;
                    last_latched  <= 1'b0;
                    state         <= ST_WAIT_DONE;
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
